// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF fetch side, LS side and RAM side.
// slave = arbiter view, master = requesters/RAM environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_err_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [MASK_W-1:0] ls_wmask_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              ls_err_o;

    logic              ram_req_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [MASK_W-1:0] ram_wmask_o;
    logic              ram_gnt_i;
    logic              ram_rvalid_i;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        input  ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        output ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch (IF) and load/store (LS); one
// transaction in flight, RAM req/gnt/rvalid handshake, optional timeout.
// Ports: clk, rst_n (async active-low), bus (mem_port_arbiter_if.slave),
// busy_o. Macro MEM_ARB_RR_EN selects round-robin on ties (default: LS wins).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                busy_o
);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t            state_q, state_d;
    logic              own_ls_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              if_rvalid_q, ls_rvalid_q;
    logic              if_err_q, ls_err_q;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    logic any_req, pick_ls, grant, rsp_tmo;

`ifdef MEM_ARB_RR_EN
    logic last_ls_q;
    // On a tie the requester that did not win last time goes first.
    assign pick_ls = bus.ls_req_i & (~bus.if_req_i | ~last_ls_q);
`else
    assign pick_ls = bus.ls_req_i;
`endif

    assign any_req = bus.if_req_i | bus.ls_req_i;
    // rst_n gate keeps gnt low while reset is held.
    assign grant   = (state_q == IDLE) & any_req & rst_n;
    // Timeout fires on the last counted RSP cycle; rvalid wins a tie.
    assign rsp_tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST)
                     && !bus.ram_rvalid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_req) state_d = REQ;
            REQ:  if (bus.ram_gnt_i) state_d = RSP;
            RSP:  if (bus.ram_rvalid_i || rsp_tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            own_ls_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            if (grant) begin
                own_ls_q <= pick_ls;
                addr_q   <= pick_ls ? bus.ls_addr_i : bus.if_addr_i;
                we_q     <= pick_ls & bus.ls_we_i;
                wdata_q  <= pick_ls ? bus.ls_wdata_i : '0;
                wmask_q  <= pick_ls ? bus.ls_wmask_i : '0;
`ifdef MEM_ARB_RR_EN
                last_ls_q <= pick_ls;
`endif
            end
            if (state_q == REQ && bus.ram_gnt_i) begin
                cnt_q <= '0;
            end else if (state_q == RSP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == RSP) begin
                if (bus.ram_rvalid_i) begin
                    if (own_ls_q) begin
                        ls_rvalid_q <= 1'b1;
                        if (!we_q) ls_rdata_q <= bus.ram_rdata_i;
                    end else begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= bus.ram_rdata_i;
                    end
                end else if (rsp_tmo) begin
                    if (own_ls_q) begin
                        ls_rvalid_q <= 1'b1;
                        ls_err_q    <= 1'b1;
                        ls_rdata_q  <= '0;
                    end else begin
                        if_rvalid_q <= 1'b1;
                        if_err_q    <= 1'b1;
                        if_rdata_q  <= '0;
                    end
                end
            end
        end
    end

    assign bus.if_gnt_o    = grant & ~pick_ls;
    assign bus.ls_gnt_o    = grant & pick_ls;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.ls_rvalid_o = ls_rvalid_q;
    assign bus.if_err_o    = if_err_q;
    assign bus.ls_err_o    = ls_err_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.ls_rdata_o  = ls_rdata_q;
    assign bus.ram_req_o   = (state_q == REQ);
    assign bus.ram_we_o    = we_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_wdata_o = wdata_q;
    assign bus.ram_wmask_o = wmask_q;
    assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level model
// checked every cycle, plus literal expectations at key cycles.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model: one outstanding transaction, waiting for RAM accept, then
    // aging in the response phase until data or timeout.
    logic        m_busy, m_iss, m_own_ls, m_last_ls, m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    int          m_age;
    logic        e_if_rv, e_ls_rv, e_if_err, e_ls_err;
    logic [63:0] e_if_rd, e_ls_rd;

    function automatic logic win_ls();
`ifdef MEM_ARB_RR_EN
        return bus.ls_req_i && (!bus.if_req_i || !m_last_ls);
`else
        return bus.ls_req_i;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_iss <= 0; m_own_ls <= 0; m_last_ls <= 1;
            m_we <= 0; m_addr <= 0; m_wdata <= 0; m_wmask <= 0;
            m_age <= 0;
            e_if_rv <= 0; e_ls_rv <= 0; e_if_err <= 0; e_ls_err <= 0;
            e_if_rd <= 0; e_ls_rd <= 0;
        end else begin
            e_if_rv <= 0; e_ls_rv <= 0; e_if_err <= 0; e_ls_err <= 0;
            if (!m_busy) begin
                if (bus.if_req_i || bus.ls_req_i) begin
                    m_busy    <= 1;
                    m_iss     <= 0;
                    m_own_ls  <= win_ls();
                    m_last_ls <= win_ls();
                    m_addr    <= win_ls() ? bus.ls_addr_i : bus.if_addr_i;
                    m_we      <= win_ls() && bus.ls_we_i;
                    m_wdata   <= win_ls() ? bus.ls_wdata_i : 64'h0;
                    m_wmask   <= win_ls() ? bus.ls_wmask_i : 8'h0;
                end
            end else if (!m_iss) begin
                if (bus.ram_gnt_i) begin
                    m_iss <= 1;
                    m_age <= 0;
                end
            end else begin
                m_age <= m_age + 1;
                if (bus.ram_rvalid_i) begin
                    m_busy <= 0;
                    if (m_own_ls) begin
                        e_ls_rv <= 1;
                        if (!m_we) e_ls_rd <= bus.ram_rdata_i;
                    end else begin
                        e_if_rv <= 1;
                        e_if_rd <= bus.ram_rdata_i;
                    end
                end else if (m_age + 1 == TMO) begin
                    m_busy <= 0;
                    if (m_own_ls) begin
                        e_ls_rv <= 1; e_ls_err <= 1; e_ls_rd <= 0;
                    end else begin
                        e_if_rv <= 1; e_if_err <= 1; e_if_rd <= 0;
                    end
                end
            end
        end
    end

    logic g_any, g_ls, r_on;
    always @(negedge clk) begin
        if (rst_n) begin
            g_any = !m_busy && (bus.if_req_i || bus.ls_req_i);
            g_ls  = win_ls();
            r_on  = m_busy && !m_iss;
            chk("m_if_gnt", bus.if_gnt_o, g_any && !g_ls);
            chk("m_ls_gnt", bus.ls_gnt_o, g_any && g_ls);
            chk("m_ram_req", bus.ram_req_o, r_on);
            if (r_on) begin
                chk("m_ram_addr", bus.ram_addr_o, m_addr);
                chk("m_ram_we", bus.ram_we_o, m_we);
                chk("m_ram_wmask", bus.ram_wmask_o, m_wmask);
                if (m_we) chk("m_ram_wdata", bus.ram_wdata_o, m_wdata);
            end
            chk("m_busy", busy, m_busy);
            chk("m_if_rvalid", bus.if_rvalid_o, e_if_rv);
            chk("m_ls_rvalid", bus.ls_rvalid_o, e_ls_rv);
            chk("m_if_err", bus.if_err_o, e_if_err);
            chk("m_ls_err", bus.ls_err_o, e_ls_err);
            chk("m_if_rdata", bus.if_rdata_o, e_if_rd);
            chk("m_ls_rdata", bus.ls_rdata_o, e_ls_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic exp_ls;

    initial begin
        bus.if_req_i = 0; bus.if_addr_i = 0;
        bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_addr_i = 0;
        bus.ls_wdata_i = 0; bus.ls_wmask_i = 0;
        bus.ram_gnt_i = 0; bus.ram_rvalid_i = 0; bus.ram_rdata_i = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ram_req", bus.ram_req_o, 0);
        chk("rst_if_rdata", bus.if_rdata_o, 0);
        chk("rst_ls_rvalid", bus.ls_rvalid_o, 0);
        tick(); tick();
        rst_n = 1;

        // fetch only
        tick(); bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0000;
        mid(); chk("f_if_gnt", bus.if_gnt_o, 1);
        tick(); bus.if_req_i = 0; bus.ram_gnt_i = 1;
        mid(); chk("f_ram_req", bus.ram_req_o, 1);
        chk("f_ram_addr", bus.ram_addr_o, 64'h8000_0000);
        chk("f_ram_we", bus.ram_we_o, 0);
        tick(); bus.ram_gnt_i = 0;
        tick(); bus.ram_rvalid_i = 1; bus.ram_rdata_i = 64'h13;
        mid(); chk("f_no_early_rv", bus.if_rvalid_o, 0);
        tick(); bus.ram_rvalid_i = 0;
        mid(); chk("f_if_rvalid", bus.if_rvalid_o, 1);
        chk("f_if_rdata", bus.if_rdata_o, 64'h13);
        chk("f_if_err", bus.if_err_o, 0);

        // tie: store vs fetch
        tick(); bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0004;
        bus.ls_req_i = 1; bus.ls_we_i = 1; bus.ls_addr_i = 32'h8000_1000;
        bus.ls_wdata_i = 64'hDEAD_BEEF; bus.ls_wmask_i = 8'h0F;
        mid();
`ifndef MEM_ARB_RR_EN
        chk("t_ls_gnt", bus.ls_gnt_o, 1);
        chk("t_if_gnt", bus.if_gnt_o, 0);
`endif
        tick(); bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ram_gnt_i = 1;
        mid();
`ifndef MEM_ARB_RR_EN
        chk("t_ram_we", bus.ram_we_o, 1);
        chk("t_ram_wdata", bus.ram_wdata_o, 64'hDEAD_BEEF);
        chk("t_ram_wmask", bus.ram_wmask_o, 64'h0F);
        chk("t_if_wait", bus.if_gnt_o, 0);
`endif
        tick(); bus.ram_gnt_i = 0; bus.ram_rvalid_i = 1;
        bus.ram_rdata_i = 64'hBAD;
        tick(); bus.ram_rvalid_i = 0;
        mid();
`ifndef MEM_ARB_RR_EN
        chk("t_ls_rvalid", bus.ls_rvalid_o, 1);
        chk("t_ls_rdata", bus.ls_rdata_o, 0);
        chk("t_if_gnt_late", bus.if_gnt_o, 1);
`endif
        tick(); bus.if_req_i = 0; bus.ram_gnt_i = 1;
        tick(); bus.ram_gnt_i = 0; bus.ram_rvalid_i = 1;
        bus.ram_rdata_i = 64'h55;
        tick(); bus.ram_rvalid_i = 0;
        mid();
`ifndef MEM_ARB_RR_EN
        chk("t_if_rdata", bus.if_rdata_o, 64'h55);
`endif

        // slow RAM, fetch waits
        tick(); bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_addr_i = 32'h100;
        mid(); chk("s_ls_gnt", bus.ls_gnt_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.ls_req_i = 0;
            bus.if_req_i = 1; bus.if_addr_i = 32'h700;
            bus.ram_gnt_i = (i == 3);
            mid();
            chk("s_ram_req", bus.ram_req_o, 1);
            chk("s_ram_addr", bus.ram_addr_o, 64'h100);
            chk("s_if_nognt", bus.if_gnt_o, 0);
        end
        tick(); bus.ram_gnt_i = 0;
        tick(); bus.ram_rvalid_i = 1;
        bus.ram_rdata_i = 64'h1234_5678_9ABC_DEF0;
        tick(); bus.ram_rvalid_i = 0;
        mid(); chk("s_ls_rdata", bus.ls_rdata_o, 64'h1234_5678_9ABC_DEF0);
        chk("s_if_gnt", bus.if_gnt_o, 1);
        tick(); bus.if_req_i = 0; bus.ram_gnt_i = 1;
        tick(); bus.ram_gnt_i = 0; bus.ram_rvalid_i = 1;
        bus.ram_rdata_i = 64'h77;
        tick(); bus.ram_rvalid_i = 0;
        mid(); chk("s_if_rdata", bus.if_rdata_o, 64'h77);

        // timeout then stray rvalid
        tick(); bus.if_req_i = 1; bus.if_addr_i = 32'h200;
        tick(); bus.if_req_i = 0; bus.ram_gnt_i = 1;
        tick(); bus.ram_gnt_i = 0;
        repeat (7) tick();
        mid(); chk("o_not_yet", bus.if_rvalid_o, 0);
        tick();
        mid(); chk("o_if_rvalid", bus.if_rvalid_o, 1);
        chk("o_if_err", bus.if_err_o, 1);
        chk("o_if_rdata", bus.if_rdata_o, 0);
        tick();
        tick(); bus.ram_rvalid_i = 1; bus.ram_rdata_i = 64'hEE;
        tick(); bus.ram_rvalid_i = 0;
        mid(); chk("o_stray", bus.if_rvalid_o, 0);
        chk("o_stray_rd", bus.if_rdata_o, 0);

        // async reset during RSP
        tick(); bus.ls_req_i = 1; bus.ls_addr_i = 32'h300;
        tick(); bus.ls_req_i = 0; bus.ram_gnt_i = 1;
        tick(); bus.ram_gnt_i = 0; bus.if_req_i = 1;
        bus.if_addr_i = 32'h600;
        mid(); chk("r_busy_pre", busy, 1);
        #2; rst_n = 0; #1;
        chk("r_busy", busy, 0);
        chk("r_if_gnt", bus.if_gnt_o, 0);
        chk("r_ls_rdata", bus.ls_rdata_o, 0);
        chk("r_if_err", bus.if_err_o, 0);
        tick(); rst_n = 1; bus.ram_rvalid_i = 1; bus.ram_rdata_i = 64'hAA;
        mid(); chk("r_fresh_gnt", bus.if_gnt_o, 1);
        tick(); bus.ram_rvalid_i = 0; bus.if_req_i = 0; bus.ram_gnt_i = 1;
        mid(); chk("r_old_ignored", bus.ls_rvalid_o, 0);
        chk("r_ram_addr", bus.ram_addr_o, 64'h600);
        tick(); bus.ram_gnt_i = 0;
        tick(); bus.ram_rvalid_i = 1; bus.ram_rdata_i = 64'h99;
        tick(); bus.ram_rvalid_i = 0;
        mid(); chk("r_if_rdata", bus.if_rdata_o, 64'h99);

        // continuous requests from both sides
        tick(); rst_n = 0;
        tick(); rst_n = 1;
        bus.if_req_i = 1; bus.if_addr_i = 32'h500;
        bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_addr_i = 32'h400;
        for (int k = 0; k < 4; k++) begin
            mid();
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2) == 1;
`else
            exp_ls = 1'b1;
`endif
            chk("c_ls_gnt", bus.ls_gnt_o, exp_ls);
            chk("c_if_gnt", bus.if_gnt_o, !exp_ls);
            tick(); bus.ram_gnt_i = 1;
            tick(); bus.ram_gnt_i = 0; bus.ram_rvalid_i = 1;
            bus.ram_rdata_i = 64'h1000 + 64'(k);
            tick(); bus.ram_rvalid_i = 0;
        end
        bus.if_req_i = 0; bus.ls_req_i = 0;
        tick(); bus.ram_gnt_i = 1;
        tick(); bus.ram_gnt_i = 0; bus.ram_rvalid_i = 1;
        bus.ram_rdata_i = 64'h2000;
        tick(); bus.ram_rvalid_i = 0;
        tick();
        mid(); chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
